// File: rtl/alb_pkg.sv
// rtl/alb_pkg.sv - shared ALB opcode, width and scoreboard types
// Purpose: common definitions for the ALB response checker and its helpers.
// Contents: ALB_DATA_WIDTH, opcode constants, expected-tuple struct, checker FSM states.
package alb_pkg;

  localparam int ALB_DATA_WIDTH = 11;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ANDN = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // One delay-line entry: what the DUT should produce for a presented vector.
  typedef struct packed {
    logic                      valid;
    logic [1:0]                op;
    logic [ALB_DATA_WIDTH-1:0] f;
    logic                      co;
    logic                      ov;
  } alb_exp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } alb_state_t;

endpackage

// File: rtl/alb_response_checker_if.sv
// rtl/alb_response_checker_if.sv - ALB stimulus/response bus shared by ALB and checker
// Purpose: bundles the vector presented to the ALB and the ALB's answer.
// Signals: valid_in, i_in (opcode), a_in, b_in, c_in (operands, carry-in),
//          f_in, co_in, ov_in (DUT result, carry-out, signed overflow).
// Modports: master drives the bus, slave (the checker) only observes it.
interface alb_response_checker_if #(
  parameter int DW = alb_pkg::ALB_DATA_WIDTH
);
  logic          valid_in;
  logic [1:0]    i_in;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          c_in;
  logic [DW-1:0] f_in;
  logic          co_in;
  logic          ov_in;

  modport master (
    output valid_in, i_in, a_in, b_in, c_in, f_in, co_in, ov_in
  );

  modport slave (
    input valid_in, i_in, a_in, b_in, c_in, f_in, co_in, ov_in
  );
endinterface

// File: rtl/alb_ref_model.sv
// rtl/alb_ref_model.sv - combinational golden ALB result
// Purpose: expected F/CO/OV for one ALB vector.
// Ports: i_op (opcode), i_a, i_b (operands), i_ci (carry-in),
//        o_f (result), o_co (carry-out), o_ov (signed overflow).
module alb_ref_model
  import alb_pkg::*;
(
  input  logic [1:0]                i_op,
  input  logic [ALB_DATA_WIDTH-1:0] i_a,
  input  logic [ALB_DATA_WIDTH-1:0] i_b,
  input  logic                      i_ci,
  output logic [ALB_DATA_WIDTH-1:0] o_f,
  output logic                      o_co,
  output logic                      o_ov
);
  localparam int MSB = ALB_DATA_WIDTH - 1;

  logic [ALB_DATA_WIDTH-1:0] w_op2;
  logic [ALB_DATA_WIDTH:0]   w_sum;

  always_comb begin
    // Subtract is B + ~A + CI, so only the second operand differs from add.
    w_op2 = (i_op == OP_SUB) ? ~i_a : i_a;
    w_sum = {1'b0, i_b} + {1'b0, w_op2} + {{ALB_DATA_WIDTH{1'b0}}, i_ci};
    o_f   = w_sum[MSB:0];
    o_co  = w_sum[ALB_DATA_WIDTH];
    o_ov  = (i_b[MSB] == w_op2[MSB]) && (w_sum[MSB] != i_b[MSB]);
    case (i_op)
      OP_OR: begin
        o_f  = i_b | i_a;
        o_co = 1'b0;
        o_ov = 1'b0;
      end
      OP_ANDN: begin
        o_f  = ~i_b & i_a;
        o_co = 1'b0;
        o_ov = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alb_response_checker.sv
// rtl/alb_response_checker.sv - scoreboard comparing ALB results against a golden model
// Purpose: captures each vector, delays its expected result by DUT_LATENCY and
//          compares it with the ALB's F/CO/OV; keeps tallies and first failure.
// Ports: clk, reset (async, active-high); bus (slave view of the ALB bus);
//        pass_count, fail_count (saturating tallies); err (mismatch pulse);
//        done (sticky); first_fail_op/exp/got (first mismatch capture).
module alb_response_checker
  import alb_pkg::*;
#(
  parameter int DATA_WIDTH  = ALB_DATA_WIDTH,
  parameter int DUT_LATENCY = 1,
  parameter int NUM_VECTORS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  alb_response_checker_if.slave bus,
  output logic [7:0]            pass_count,
  output logic [7:0]            fail_count,
  output logic                  err,
  output logic                  done,
  output logic [1:0]            first_fail_op,
  output logic [DATA_WIDTH-1:0] first_fail_exp,
  output logic [DATA_WIDTH-1:0] first_fail_got
);
  logic [DATA_WIDTH-1:0] w_ref_f;
  logic                  w_ref_co;
  logic                  w_ref_ov;
  alb_exp_t              w_exp_in;
  alb_exp_t              w_tail;
  alb_exp_t              r_dly [DUT_LATENCY];

  alb_state_t            r_state;
  alb_state_t            w_state_nxt;
  logic [7:0]            r_pass;
  logic [7:0]            r_fail;
  logic [7:0]            w_pass_nxt;
  logic [7:0]            w_fail_nxt;
  logic [8:0]            w_total_nxt;
  logic                  r_err;
  logic                  r_captured;
  logic [1:0]            r_ff_op;
  logic [DATA_WIDTH-1:0] r_ff_exp;
  logic [DATA_WIDTH-1:0] r_ff_got;
  logic                  w_match;
  logic                  w_check;
  logic                  w_fail;

  alb_ref_model u_ref (
    .i_op (bus.i_in),
    .i_a  (bus.a_in),
    .i_b  (bus.b_in),
    .i_ci (bus.c_in),
    .o_f  (w_ref_f),
    .o_co (w_ref_co),
    .o_ov (w_ref_ov)
  );

  assign w_exp_in = {bus.valid_in, bus.i_in, w_ref_f, w_ref_co, w_ref_ov};

  // Shifts every cycle so the tail lines up with the DUT result for that vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DUT_LATENCY; k++) r_dly[k] <= '0;
    end else begin
      r_dly[0] <= w_exp_in;
      for (int k = 1; k < DUT_LATENCY; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign w_tail = r_dly[DUT_LATENCY-1];

  // Logic ops (op[0]==0) leave CO/OV undefined, so only F is compared for them.
  assign w_match = (w_tail.f == bus.f_in) &&
                   (!w_tail.op[0] || ((w_tail.co == bus.co_in) && (w_tail.ov == bus.ov_in)));
  assign w_check = w_tail.valid && (r_state == S_RUN);
  assign w_fail  = w_check && !w_match;

  assign w_pass_nxt  = (w_check && w_match && (r_pass != 8'hFF)) ? r_pass + 8'd1 : r_pass;
  assign w_fail_nxt  = (w_fail && (r_fail != 8'hFF)) ? r_fail + 8'd1 : r_fail;
  assign w_total_nxt = {1'b0, w_pass_nxt} + {1'b0, w_fail_nxt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // DONE is entered on the edge of the final count update so done and the
  // last tally appear together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.valid_in) w_state_nxt = S_RUN;
      S_RUN:   if (w_total_nxt >= 9'(NUM_VECTORS)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass     <= '0;
      r_fail     <= '0;
      r_err      <= 1'b0;
      r_captured <= 1'b0;
      r_ff_op    <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else begin
      r_pass <= w_pass_nxt;
      r_fail <= w_fail_nxt;
      r_err  <= w_fail;
      if (w_fail && !r_captured) begin
        r_captured <= 1'b1;
        r_ff_op    <= w_tail.op;
        r_ff_exp   <= w_tail.f;
        r_ff_got   <= bus.f_in;
      end
    end
  end

  assign pass_count     = r_pass;
  assign fail_count     = r_fail;
  assign err            = r_err;
  assign done           = (r_state == S_DONE);
  assign first_fail_op  = r_ff_op;
  assign first_fail_exp = r_ff_exp;
  assign first_fail_got = r_ff_got;
endmodule

// File: tb/tb_alb_response_checker.sv
// tb/tb_alb_response_checker.sv - self-checking bench for alb_response_checker
module tb_alb_response_checker;
  localparam int LAT = 2;
  localparam int NV  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pass_count, fail_count;
  logic        err, done;
  logic [1:0]  first_fail_op;
  logic [10:0] first_fail_exp, first_fail_got;

  always #5 clk = ~clk;

  alb_response_checker_if bus ();

  alb_response_checker #(
    .DATA_WIDTH  (11),
    .DUT_LATENCY (LAT),
    .NUM_VECTORS (NV)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .bus            (bus),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .err            (err),
    .done           (done),
    .first_fail_op  (first_fail_op),
    .first_fail_exp (first_fail_exp),
    .first_fail_got (first_fail_got)
  );

  // One in-flight vector as seen by the bench: outcome (0 none, 1 pass, 2 fail)
  // plus the response the "DUT" will present when its turn comes.
  typedef struct {
    int tok;
    int op;
    int ef;
    int gf;
    int gco;
    int gov;
  } slot_t;

  slot_t pipe[$];
  int e_pass, e_fail, e_err, e_done, e_cap, e_op, e_exp, e_got;
  int n_vec, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden ALB behaviour from signed/unsigned integer arithmetic.
  function automatic void ref_calc(input int op, input int a, input int b, input int ci,
                                   output int f, output int co, output int ov);
    int sa, sb, t;
    sa = (a >= 1024) ? a - 2048 : a;
    sb = (b >= 1024) ? b - 2048 : b;
    f = 0; co = 0; ov = 0;
    case (op)
      0: f = b | a;
      2: f = (~b) & a & 2047;
      1: begin
        t  = b + a + ci;
        f  = t % 2048;
        co = t / 2048;
        t  = sb + sa + ci;
        ov = (t > 1023 || t < -1024) ? 1 : 0;
      end
      default: begin
        t  = b + (2047 - a) + ci;
        f  = t % 2048;
        co = t / 2048;
        t  = sb - sa - 1 + ci;
        ov = (t > 1023 || t < -1024) ? 1 : 0;
      end
    endcase
  endfunction

  task automatic model_reset();
    slot_t s;
    e_pass = 0; e_fail = 0; e_err = 0; e_done = 0;
    e_cap = 0; e_op = 0; e_exp = 0; e_got = 0;
    pipe.delete();
    s = '{tok: 0, op: 0, ef: 0, gf: 0, gco: 0, gov: 0};
    repeat (LAT) pipe.push_back(s);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pass"}, 32'(pass_count), e_pass);
    chk({tag, ":fail"}, 32'(fail_count), e_fail);
    chk({tag, ":err"}, 32'(err), e_err);
    chk({tag, ":done"}, 32'(done), e_done);
    chk({tag, ":ff_op"}, 32'(first_fail_op), e_op);
    chk({tag, ":ff_exp"}, 32'(first_fail_exp), e_exp);
    chk({tag, ":ff_got"}, 32'(first_fail_got), e_got);
  endtask

  // One clock: present a vector (or a gap) plus the response owed to the vector
  // presented LAT cycles earlier, then update the expectations and compare.
  task automatic step(input bit v, input int op, input int a, input int b, input int ci,
                      input int rf, input int rco, input int rov, input string tag);
    int ef, eco, eov;
    bit ok;
    slot_t s, cur;
    ref_calc(op, a, b, ci, ef, eco, eov);
    if (v) begin
      ok = (rf == ef) && ((op % 2 == 0) || (rco == eco && rov == eov));
      s = '{tok: ok ? 1 : 2, op: op, ef: ef, gf: rf, gco: rco, gov: rov};
    end else begin
      s = '{tok: 0, op: 0, ef: 0, gf: int'($urandom_range(2047)),
            gco: int'($urandom_range(1)), gov: int'($urandom_range(1))};
    end
    pipe.push_back(s);
    cur = pipe.pop_front();
    bus.valid_in = v;
    bus.i_in     = op[1:0];
    bus.a_in     = a[10:0];
    bus.b_in     = b[10:0];
    bus.c_in     = ci[0];
    bus.f_in     = cur.gf[10:0];
    bus.co_in    = cur.gco[0];
    bus.ov_in    = cur.gov[0];
    @(posedge clk);
    #1;
    e_err = 0;
    if (cur.tok != 0 && e_done == 0) begin
      if (cur.tok == 1) begin
        if (e_pass < 255) e_pass++;
      end else begin
        if (e_fail < 255) e_fail++;
        e_err = 1;
        if (e_cap == 0) begin
          e_cap = 1; e_op = cur.op; e_exp = cur.ef; e_got = cur.gf;
        end
      end
      if (e_pass + e_fail >= NV) e_done = 1;
    end
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "gap");
  endtask

  // Random vector with a correct response, or F corrupted when bad is set.
  // CO/OV of logic ops are randomised since the checker must ignore them.
  task automatic vec(input bit bad, input string tag, output int got_f);
    int op, a, b, ci, ef, eco, eov, rco, rov;
    op = int'($urandom_range(3));
    a  = int'($urandom_range(2047));
    b  = int'($urandom_range(2047));
    ci = int'($urandom_range(1));
    ref_calc(op, a, b, ci, ef, eco, eov);
    got_f = bad ? (ef ^ 'h155) : ef;
    rco = (op % 2 == 0) ? int'($urandom_range(1)) : eco;
    rov = (op % 2 == 0) ? int'($urandom_range(1)) : eov;
    step(1, op, a, b, ci, got_f, rco, rov, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all({tag, ":async"});
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_sweep(input int bad_idx, output int bad_f);
    int gf;
    bad_f = 0;
    for (int i = 0; i < NV; i++) begin
      vec(i == bad_idx, "sweep", gf);
      if (i == bad_idx) bad_f = gf;
    end
    idle(LAT);
  endtask

  initial begin
    int bad_f, gf;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.i_in = '0; bus.a_in = '0; bus.b_in = '0;
    bus.c_in = 1'b0; bus.f_in = '0; bus.co_in = 1'b0; bus.ov_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Directed vectors with a gap in between.
    step(1, 0, 'h400, 'h001, 0, 'h401, 0, 0, "or");
    idle(1);
    step(1, 2, 'h7FF, 'h555, 0, 'h2AA, 1, 1, "andn");
    step(1, 1, 663, 398, 0, 'h425, 0, 1, "add_ov");
    step(1, 1, 663, 398, 0, 'h425, 0, 0, "add_ov_bad");
    step(1, 3, 663, 398, 1, 'h6F7, 0, 0, "sub");
    idle(LAT + 1);
    chk("dir_pass", 32'(pass_count), 4);
    chk("dir_fail", 32'(fail_count), 1);
    chk("dir_ff_op", 32'(first_fail_op), 1);
    chk("dir_ff_exp", 32'(first_fail_exp), 'h425);
    chk("dir_ff_got", 32'(first_fail_got), 'h425);
    chk("dir_done", 32'(done), 0);

    // Back-to-back sweep with the fourth vector corrupted.
    do_reset("rst1");
    run_sweep(3, bad_f);
    chk("sweep_pass", 32'(pass_count), 9);
    chk("sweep_fail", 32'(fail_count), 1);
    chk("sweep_done", 32'(done), 1);
    chk("sweep_ff_got", 32'(first_fail_got), bad_f);

    // After done, further vectors (even bad ones) change nothing.
    vec(1, "post_done", gf);
    vec(0, "post_done", gf);
    vec(1, "post_done", gf);
    idle(LAT);
    chk("post_pass", 32'(pass_count), 9);
    chk("post_fail", 32'(fail_count), 1);
    chk("post_err", 32'(err), 0);

    // Mismatch on the last vector: err and done rise together.
    do_reset("rst2");
    run_sweep(NV - 1, bad_f);
    chk("last_err", 32'(err), 1);
    chk("last_done", 32'(done), 1);
    chk("last_fail", 32'(fail_count), 1);

    // Reset with vectors in flight: nothing stale may be checked afterwards.
    do_reset("rst3");
    vec(0, "pre_mid", gf);
    vec(0, "pre_mid", gf);
    vec(1, "pre_mid", gf);
    do_reset("mid");
    idle(LAT + 2);
    chk("mid_pass", 32'(pass_count), 0);
    chk("mid_fail", 32'(fail_count), 0);
    vec(0, "after_mid", gf);
    idle(LAT);
    chk("after_mid_pass", 32'(pass_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
